// File: rtl/risc_pkg.sv
// Shared definitions for the execute-feed slice: datapath sizes, ALU opcodes
// and the issue-slot state encoding.
package risc_pkg;

    localparam int DW     = 32;
    localparam int NREG   = 16;
    localparam int IMMW   = 16;
    localparam int RIDX_W = $clog2(NREG);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_EQ  = 4'd8;
    localparam logic [3:0] ALU_LT  = 4'd10;
    localparam logic [3:0] ALU_LE  = 4'd11;
    localparam logic [3:0] ALU_GT  = 4'd13;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/operand_issue_if.sv
// Issue-side, ALU-side and writeback signals of the operand issue stage.
// The master drives decoded instructions, ALU ready and writebacks.
// The slave is the issue stage itself.
interface operand_issue_if #(
    parameter int DW   = risc_pkg::DW,
    parameter int IMMW = risc_pkg::IMMW
);
    import risc_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_oper;
    logic [RIDX_W-1:0]   in_rd;
    logic [RIDX_W-1:0]   in_rs1;
    logic [RIDX_W-1:0]   in_rs2;
    logic                in_use_imm;
    logic [IMMW-1:0]     in_imm;

    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_a;
    logic [DW-1:0]       out_b;
    logic [3:0]          out_oper;
    logic [RIDX_W-1:0]   out_rd;

    logic                wb_en;
    logic [RIDX_W-1:0]   wb_rd;
    logic [DW-1:0]       wb_data;

    modport master (
        output in_valid, in_oper, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  in_ready,
        input  out_valid, out_a, out_b, out_oper, out_rd,
        output out_ready,
        output wb_en, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_oper, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output in_ready,
        output out_valid, out_a, out_b, out_oper, out_rd,
        input  out_ready,
        input  wb_en, wb_rd, wb_data
    );

endinterface

// File: rtl/operand_issue_reg_file.sv
// 2-read / 1-write register file. Reads are asynchronous, r0 always reads
// zero, and a same-cycle write to the addressed register is forwarded.
module reg_file_2r1w #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] mem_q [NREG];

    // Storage: cleared on reset, written on the clock edge, r0 never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && wa_i != '0) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Read ports: r0 forced to zero, otherwise writeback bypass ahead of storage
    always_comb begin
        rd1_o = mem_q[ra1_i];
        rd2_o = mem_q[ra2_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && wa_i == ra1_i) begin
            rd1_o = wd_i;
        end
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && wa_i == ra2_i) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/operand_issue.sv
// Execute-feed stage: reads operands (with writeback bypass), selects the
// register or sign-extended immediate for B, stalls on RAW/WAW hazards via a
// per-register pending scoreboard, and holds the op in a one-entry ALU slot.
module operand_issue #(
    parameter int DW   = risc_pkg::DW,
    parameter int NREG = risc_pkg::NREG,
    parameter int IMMW = risc_pkg::IMMW
) (
    input  logic           clk,
    input  logic           rst,
    operand_issue_if.slave bus
);
    import risc_pkg::*;

    slot_state_t        state_q, state_d;
    logic [NREG-1:0]    pend_q, pend_d;
    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      b_q, b_d;
    logic [3:0]         oper_q, oper_d;
    logic [RIDX_W-1:0]  rd_q, rd_d;

    logic [DW-1:0]      rs1_val, rs2_val, b_sel;
    logic               busy_rs1, busy_rs2, busy_rd, hazard;
    logic               slot_free, accept, wb_clr;

    reg_file_2r1w #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (RIDX_W)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (bus.in_rs1),
        .ra2_i (bus.in_rs2),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val),
        .we_i  (bus.wb_en),
        .wa_i  (bus.wb_rd),
        .wd_i  (bus.wb_data)
    );

    // Hazard detection, handshake and operand B selection
    always_comb begin
        busy_rs1  = (bus.in_rs1 != '0) && pend_q[bus.in_rs1] &&
                    !(bus.wb_en && bus.wb_rd == bus.in_rs1);
        busy_rs2  = (bus.in_rs2 != '0) && pend_q[bus.in_rs2] &&
                    !(bus.wb_en && bus.wb_rd == bus.in_rs2);
        busy_rd   = (bus.in_rd != '0) && pend_q[bus.in_rd] &&
                    !(bus.wb_en && bus.wb_rd == bus.in_rd);
        hazard    = busy_rs1 || (!bus.in_use_imm && busy_rs2) || busy_rd;
        slot_free = (state_q == SLOT_EMPTY) || bus.out_ready;
        accept    = bus.in_valid && slot_free && !hazard;
        wb_clr    = bus.wb_en && bus.wb_rd != '0;
        b_sel     = bus.in_use_imm ? {{(DW-IMMW){bus.in_imm[IMMW-1]}}, bus.in_imm}
                                   : rs2_val;
    end

    assign bus.in_ready  = slot_free && !hazard;
    assign bus.out_valid = (state_q == SLOT_FULL);
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_oper  = oper_q;
    assign bus.out_rd    = rd_q;

    // Slot next state: fill on accept, drain on consume without refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (!accept && bus.out_ready) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Slot payload and scoreboard next values; a set after the clear wins
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        oper_d = oper_q;
        rd_d   = rd_q;
        pend_d = pend_q;
        if (wb_clr) begin
            pend_d[bus.wb_rd] = 1'b0;
        end
        if (accept) begin
            a_d    = rs1_val;
            b_d    = b_sel;
            oper_d = bus.in_oper;
            rd_d   = bus.in_rd;
            if (bus.in_rd != '0) begin
                pend_d[bus.in_rd] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            pend_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            oper_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oper_q  <= oper_d;
            rd_q    <= rd_d;
        end
    end

endmodule
